// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0 (SR/Cause/EPC/PRId, optional CP0_TIMER_EN timer)
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2022_1120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_din,
    output logic [31:0] cp0_dout,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_ti;
    logic [5:0]  w_ip_eff;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_dout;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    assign w_ti     = r_ti;
    assign w_ip_eff = {hw_int[5] | r_ti, hw_int[4:0]};

    // Free-running counter and compare match; software writes win over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            if (en && !w_req && cp0_addr == ADDR_COUNT)
                r_count <= cp0_din;
            else
                r_count <= r_count + 32'd1;
            if (en && !w_req && cp0_addr == ADDR_COMPARE) begin
                r_compare <= cp0_din;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'd0) begin
                r_ti      <= 1'b1;
            end
        end
    end
`else
    assign w_ti     = 1'b0;
    assign w_ip_eff = hw_int;
`endif

    assign w_int_req = (|(w_ip_eff & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (exc_code_in != 5'd0) & ~r_exl;
    assign w_req     = (w_int_req | w_exc_req) & ~reset;
    assign req       = w_req;

    assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
    assign w_cause = {r_bd, w_ti, 14'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

    // EPC forwarding lets an mtc0 EPC immediately ahead of eret take effect.
    assign epc_out = (en && cp0_addr == ADDR_EPC) ? cp0_din : r_epc;

    // Exception entry takes priority over eret and over any concurrent mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= w_ip_eff;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bd_in;
                r_epc      <= bd_in ? (vpc - 32'd4) : vpc;
                r_exc_code <= w_int_req ? 5'd0 : exc_code_in;
            end else begin
                if (exl_clr)
                    r_exl <= 1'b0;
                if (en && cp0_addr == ADDR_SR) begin
                    r_im  <= cp0_din[15:10];
                    r_exl <= cp0_din[1];
                    r_ie  <= cp0_din[0];
                end
                if (en && cp0_addr == ADDR_EPC)
                    r_epc <= cp0_din;
            end
        end
    end

    // Combinational mfc0 read mux; unmapped addresses return zero.
    always_comb begin
        w_dout = 32'd0;
        case (cp0_addr)
            ADDR_SR:      w_dout = w_sr;
            ADDR_CAUSE:   w_dout = w_cause;
            ADDR_EPC:     w_dout = r_epc;
            ADDR_PRID:    w_dout = PRID;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   w_dout = r_count;
            ADDR_COMPARE: w_dout = r_compare;
`endif
            default:      w_dout = 32'd0;
        endcase
    end

    assign cp0_dout = w_dout;

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the five-stage MIPS pipeline, sitting at the M stage. It holds SR, Cause, EPC and PRId, and arbitrates external interrupts against the exception code carried down the pipeline. It drives `req`, the flush/redirect strobe that every pipeline register consumes; on `req` they load the handler PC 0x0000_4180. It also services `mtc0`/`mfc0` accesses and `eret`.

## Interface
- `PRID`, default 32'h2022_1120, read-only value returned at address 15.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `en` in 1: `mtc0` write strobe from the M stage.
- `cp0_addr` in 5: register number for both read and write.
- `cp0_din` in 32: `mtc0` write data.
- `cp0_dout` out 32: `mfc0` read data, combinational.
- `vpc` in 32: PC of the instruction in M.
- `bd_in` in 1: the M instruction sits in a delay slot.
- `exc_code_in` in 5: exception code from M; 0 means no exception.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `exl_clr` in 1: `eret` is in M.
- `req` out 1: take an exception or interrupt this cycle; combinational.
- `epc_out` out 32: return address for `eret`.

## Operation
- **SR (12):** IM = bits[15:10], EXL = bit 1, IE = bit 0. All other bits read 0 and ignore writes.
- **Cause (13):** BD = bit 31, TI = bit 30, IP = bits[15:10], ExcCode = bits[6:2]. Software writes are ignored.
  - IP is re-registered every cycle from the effective interrupt vector `ip_eff`.
  - Without the timer, `ip_eff = hw_int`.
- **EPC (14):** full 32-bit register, writable by `mtc0`.
- **PRId (15):** constant `PRID`.
- **Unmapped reads:** any other address reads 0.
- **Request logic:**
  - `int_req = |(ip_eff & IM) & IE & ~EXL`
  - `exc_req = (exc_code_in != 0) & ~EXL`
  - `req = (int_req | exc_req) & ~reset`
- **Priority:** interrupt beats exception. On an interrupt, ExcCode latches 0. Otherwise ExcCode latches `exc_code_in`.
- **On `req` at posedge:**
  - EXL <= 1.
  - BD <= `bd_in`.
  - EPC <= `bd_in ? vpc - 4 : vpc` (32-bit modular arithmetic).
  - A concurrent `mtc0` is discarded.
- **On `exl_clr` without `req`:** EXL <= 0. If `req` and `exl_clr` are both set, `req` wins.
- **Write priority:** `mtc0` applies only when `req` = 0. SR writes update IM, EXL and IE together.
- **`epc_out`:**
  - Equals EPC.
  - When `en` = 1 and `cp0_addr` = 14 in the same cycle, it forwards `cp0_din` instead. This lets `mtc0 EPC` directly ahead of `eret` resolve.

## Timing
- **Reset values:** SR = 0, Cause = 0, EPC = 0, Count = 0, Compare = 0, `req` = 0, `cp0_dout` = 0 for every address except 15.
- `req` is valid in the same cycle as its inputs. The pipeline flush and the register updates happen at the following posedge.
- `cp0_dout` reflects register state before the current edge. There is no read-after-write bypass except for `epc_out`.
- IP samples `ip_eff` once per cycle, so software sees an interrupt in Cause one cycle after it asserts. `req` itself uses live `ip_eff` with no delay.
- **While EXL = 1:** `req` is suppressed, and IP still tracks the lines.
- **Reset mid-handler:** EXL clears, and `req` is forced 0 during the reset cycle.

## Configuration
- **`CP0_TIMER_EN` defined:**
  - Adds Count (9) and Compare (11), both readable and writable.
  - Count increments every cycle and wraps at 2^32. An `mtc0` to Count overrides that cycle's increment.
  - When Count == Compare and Compare != 0, TI <= 1.
  - An `mtc0` to Compare clears TI.
  - `ip_eff = {hw_int[5] | TI, hw_int[4:0]}`.
- **Undefined:**
  - Addresses 9 and 11 read 0 and ignore writes.
  - TI reads 0.
  - `ip_eff = hw_int`.

## Test plan
- **Reset state:** reset for 2 cycles, then read 12, 13, 14 and 15 → 0, 0, 0, `PRID`; `req` = 0.
- **Enabled interrupt:** `mtc0` SR = 0x0000_0401, then `hw_int` = 6'b000001 with `vpc` = 0x3010 → `req` = 1 that cycle. Next cycle: SR = 0x0000_0403, EPC = 0x3010, ExcCode = 0, `req` = 0.
- **Exception in delay slot:** `exc_code_in` = 12, `bd_in` = 1, `vpc` = 0x3024, EXL = 0 → `req` = 1. Then EPC = 0x3020, Cause[31] = 1, Cause[6:2] = 12.
- **Interrupt beats exception:** SR = 0x0000_0401, `hw_int`[0] = 1 and `exc_code_in` = 4 in the same cycle → ExcCode latches 0.
- **`eret` and EPC bypass:** with EXL = 1, `mtc0` EPC = 0x4000 with `exl_clr` asserted in the same cycle → `epc_out` = 0x4000 combinationally, and SR EXL = 0 after the edge.
- **Timer (`CP0_TIMER_EN`):** Compare = 5, SR = 0x0000_8001, Count = 0 → TI = 1 and `req` = 1 within 7 cycles. A subsequent `mtc0` Compare clears Cause[30].
